// File: rtl/regfile_wb_ctrl_if.sv
// Writeback bus between the result producers and the register-file write
// controller.
//   p_valid/p_addr/p_data       : in-order pipeline writeback (always accepted)
//   m_valid/m_ready/m_addr/m_data: multi-cycle unit result handshake
//   we/waddr/wdata              : register file write port (registered)
//   pend_mask                   : per-register pending source M write
//   q_count                     : source M FIFO occupancy
// master = producer/register-file side, slave = controller.
interface regfile_wb_ctrl_if #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic              p_valid;
    logic [ADDR_W-1:0] p_addr;
    logic [DATA_W-1:0] p_data;
    logic              m_valid;
    logic              m_ready;
    logic [ADDR_W-1:0] m_addr;
    logic [DATA_W-1:0] m_data;
    logic              we;
    logic [ADDR_W-1:0] waddr;
    logic [DATA_W-1:0] wdata;
    logic [31:0]       pend_mask;
    logic [CW-1:0]     q_count;

    modport master (
        output p_valid, p_addr, p_data, m_valid, m_addr, m_data,
        input  m_ready, we, waddr, wdata, pend_mask, q_count
    );

    modport slave (
        input  p_valid, p_addr, p_data, m_valid, m_addr, m_data,
        output m_ready, we, waddr, wdata, pend_mask, q_count
    );
endinterface

// File: rtl/regfile_wb_ctrl.sv
// Register file write-side controller.
// Merges pipeline writebacks (source P, always accepted, highest priority)
// with multi-cycle unit results (source M, queued in a DEPTH-entry FIFO) onto
// the single register-file write port. The port outputs are registered: a
// request selected in cycle N is visible on we/waddr/wdata after edge N+1.
// WAW hazards: M results are older than any concurrent/later P write, so a
// P write to register A kills every queued M entry targeting A (including
// one enqueued in the same cycle). Killed entries drain silently.
// Ports:
//   clk, rst : clock, synchronous active-high reset
//   bus      : regfile_wb_ctrl_if.slave (P/M requests, write port,
//              pend_mask, q_count)
// Optional feature macro WB_BYPASS_EN: adds ra_addr/rb_addr inputs and
//   ra/rb_fwd_hit, ra/rb_fwd_data outputs that forward the value currently on
//   the write port to the decode stage.
module regfile_wb_ctrl #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                rst,
    regfile_wb_ctrl_if.slave    bus
`ifdef WB_BYPASS_EN
    ,
    input  logic [ADDR_W-1:0]   ra_addr,
    input  logic [ADDR_W-1:0]   rb_addr,
    output logic                ra_fwd_hit,
    output logic                rb_fwd_hit,
    output logic [DATA_W-1:0]   ra_fwd_data,
    output logic [DATA_W-1:0]   rb_fwd_data
`endif
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [ADDR_W-1:0] mem_addr [DEPTH];
    logic [DATA_W-1:0] mem_data [DEPTH];
    logic [DEPTH-1:0]  live;        // occupied and not killed
    logic [PW-1:0]     rd_ptr;
    logic [PW-1:0]     wr_ptr;
    logic [CW-1:0]     count;

    logic              we_q;
    logic [ADDR_W-1:0] waddr_q;
    logic [DATA_W-1:0] wdata_q;

    logic enq;
    logic deq;
    logic m_ready;
    logic same_addr;

    assign m_ready   = !rst && (count < FULL);
    assign enq       = bus.m_valid && m_ready;
    // P has the port whenever it is valid; the FIFO drains only in idle P cycles.
    assign deq       = !bus.p_valid && (count != '0);
    assign same_addr = bus.p_valid && (bus.m_addr == bus.p_addr);

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count   <= '0;
            live    <= '0;
            we_q    <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
        end else begin
            // Kill older queued writes to the register P is writing now.
            if (bus.p_valid) begin
                for (int i = 0; i < DEPTH; i++) begin
                    if (mem_addr[i] == bus.p_addr)
                        live[i] <= 1'b0;
                end
            end
            // Enqueue slot never aliases the dequeue slot: equal pointers
            // mean empty (no dequeue) or full (no enqueue).
            if (enq) begin
                mem_addr[wr_ptr] <= bus.m_addr;
                mem_data[wr_ptr] <= bus.m_data;
                live[wr_ptr]     <= !same_addr;
                wr_ptr           <= wr_ptr + 1'b1;
            end
            if (deq) begin
                live[rd_ptr] <= 1'b0;
                rd_ptr       <= rd_ptr + 1'b1;
            end
            case ({enq, deq})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase

            if (bus.p_valid) begin
                we_q    <= (bus.p_addr != '0);
                waddr_q <= bus.p_addr;
                wdata_q <= bus.p_data;
            end else if (deq) begin
                we_q    <= live[rd_ptr] && (mem_addr[rd_ptr] != '0);
                waddr_q <= mem_addr[rd_ptr];
                wdata_q <= mem_data[rd_ptr];
            end else begin
                we_q    <= 1'b0;
            end
        end
    end

    // Derived from registered live/addr state, so it moves on the same edge
    // as enqueue, dequeue and kill.
    always_comb begin
        bus.pend_mask = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (live[i])
                bus.pend_mask[5'(mem_addr[i])] = 1'b1;
        end
        bus.pend_mask[0] = 1'b0;
    end

    assign bus.m_ready = m_ready;
    assign bus.q_count = count;
    assign bus.we      = we_q;
    assign bus.waddr   = waddr_q;
    assign bus.wdata   = wdata_q;

`ifdef WB_BYPASS_EN
    assign ra_fwd_hit  = we_q && (waddr_q == ra_addr) && (ra_addr != '0);
    assign rb_fwd_hit  = we_q && (waddr_q == rb_addr) && (rb_addr != '0);
    assign ra_fwd_data = ra_fwd_hit ? wdata_q : '0;
    assign rb_fwd_data = rb_fwd_hit ? wdata_q : '0;
`endif
endmodule

// File: tb/tb_regfile_wb_ctrl.sv
// Directed testbench for regfile_wb_ctrl: reset, P writes, M queue drain,
// full FIFO back-pressure, WAW kill (staggered and same-cycle), mid-op reset.
module tb_regfile_wb_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    regfile_wb_ctrl_if #(.DEPTH(4), .ADDR_W(5), .DATA_W(32)) bus();

`ifdef WB_BYPASS_EN
    logic [4:0]  ra_addr = '0, rb_addr = '0;
    logic        ra_fwd_hit, rb_fwd_hit;
    logic [31:0] ra_fwd_data, rb_fwd_data;
`endif

    regfile_wb_ctrl #(.DEPTH(4), .ADDR_W(5), .DATA_W(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
`ifdef WB_BYPASS_EN
        ,
        .ra_addr     (ra_addr),
        .rb_addr     (rb_addr),
        .ra_fwd_hit  (ra_fwd_hit),
        .rb_fwd_hit  (rb_fwd_hit),
        .ra_fwd_data (ra_fwd_data),
        .rb_fwd_data (rb_fwd_data)
`endif
    );

    // Advance one edge and settle; outputs sampled 1 time unit after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.p_valid = 1'b0; bus.p_addr = '0; bus.p_data = '0;
        bus.m_valid = 1'b0; bus.m_addr = '0; bus.m_data = '0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b1;
        bus.p_valid = 1'b1; bus.p_addr = 5'd3; bus.p_data = 32'h1;
        tick(); tick();
        n_checks++; if (bus.we !== 1'b0) begin n_fail++; $display("FAIL reset_we: got %b want 0", bus.we); end
        n_checks++; if (bus.m_ready !== 1'b0) begin n_fail++; $display("FAIL reset_m_ready: got %b want 0", bus.m_ready); end
        n_checks++; if (bus.pend_mask !== 32'h0) begin n_fail++; $display("FAIL reset_pend: got %h want 0", bus.pend_mask); end
        rst = 1'b0;
        idle_inputs();
        #1;
        n_checks++; if (bus.m_ready !== 1'b1) begin n_fail++; $display("FAIL release_m_ready: got %b want 1", bus.m_ready); end
        tick();
        n_checks++; if (bus.q_count !== 3'd0) begin n_fail++; $display("FAIL release_q_count: got %0d want 0", bus.q_count); end
        n_checks++; if (bus.we !== 1'b0) begin n_fail++; $display("FAIL release_we: got %b want 0", bus.we); end
    endtask

    task automatic test_p_write();
        bus.p_valid = 1'b1; bus.p_addr = 5'd3; bus.p_data = 32'h1234;
        tick();
        bus.p_valid = 1'b0;
        n_checks++; if ({bus.we, bus.waddr, bus.wdata} !== {1'b1, 5'd3, 32'h1234})
            begin n_fail++; $display("FAIL p_write: got we=%b a=%0d d=%h want we=1 a=3 d=1234", bus.we, bus.waddr, bus.wdata); end
        tick();
        n_checks++; if (bus.we !== 1'b0) begin n_fail++; $display("FAIL p_write_one_cycle: got we=%b want 0", bus.we); end
        bus.p_valid = 1'b1; bus.p_addr = 5'd0; bus.p_data = 32'h55;
        tick();
        bus.p_valid = 1'b0;
        n_checks++; if (bus.we !== 1'b0) begin n_fail++; $display("FAIL p_write_r0: got we=%b want 0", bus.we); end
        tick();
    endtask

    task automatic test_m_drain();
        bus.m_valid = 1'b1; bus.m_addr = 5'd5; bus.m_data = 32'hAA;
        tick();  // 5 queued, nothing to drain yet
        n_checks++; if (bus.pend_mask !== 32'h20) begin n_fail++; $display("FAIL m_pend5: got %h want 00000020", bus.pend_mask); end
        n_checks++; if (bus.we !== 1'b0) begin n_fail++; $display("FAIL m_no_bypass: got we=%b want 0", bus.we); end
        bus.m_addr = 5'd6; bus.m_data = 32'hBB;
        tick();  // 6 queued, 5 drained
        bus.m_valid = 1'b0;
        n_checks++; if ({bus.we, bus.waddr, bus.wdata} !== {1'b1, 5'd5, 32'hAA})
            begin n_fail++; $display("FAIL m_drain5: got we=%b a=%0d d=%h want we=1 a=5 d=aa", bus.we, bus.waddr, bus.wdata); end
        n_checks++; if (bus.pend_mask !== 32'h40) begin n_fail++; $display("FAIL m_pend6: got %h want 00000040", bus.pend_mask); end
        tick();
        n_checks++; if ({bus.we, bus.waddr, bus.wdata} !== {1'b1, 5'd6, 32'hBB})
            begin n_fail++; $display("FAIL m_drain6: got we=%b a=%0d d=%h want we=1 a=6 d=bb", bus.we, bus.waddr, bus.wdata); end
        n_checks++; if (bus.pend_mask !== 32'h0 || bus.q_count !== 3'd0)
            begin n_fail++; $display("FAIL m_empty: got pend=%h cnt=%0d want 0 0", bus.pend_mask, bus.q_count); end
        tick();
        n_checks++; if (bus.we !== 1'b0) begin n_fail++; $display("FAIL m_idle: got we=%b want 0", bus.we); end
    endtask

    task automatic test_full();
        bus.p_valid = 1'b1; bus.p_addr = 5'd9; bus.p_data = 32'h99;
        for (int i = 0; i < 4; i++) begin
            bus.m_valid = 1'b1; bus.m_addr = 5'(10 + i); bus.m_data = 32'h100 + i;
            #1;
            n_checks++; if (bus.m_ready !== 1'b1) begin n_fail++; $display("FAIL full_ready%0d: got %b want 1", i, bus.m_ready); end
            tick();
        end
        n_checks++; if (bus.m_ready !== 1'b0 || bus.q_count !== 3'd4)
            begin n_fail++; $display("FAIL full_state: got rdy=%b cnt=%0d want 0 4", bus.m_ready, bus.q_count); end
        n_checks++; if ({bus.we, bus.waddr} !== {1'b1, 5'd9})
            begin n_fail++; $display("FAIL full_p_write: got we=%b a=%0d want 1 9", bus.we, bus.waddr); end
        bus.m_addr = 5'd14; bus.m_data = 32'hDEAD;  // 5th request, must be refused
        tick();
        n_checks++; if (bus.q_count !== 3'd4 || bus.pend_mask !== 32'h3C00)
            begin n_fail++; $display("FAIL full_refuse: got cnt=%0d pend=%h want 4 00003c00", bus.q_count, bus.pend_mask); end
        bus.m_valid = 1'b0; bus.p_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            n_checks++; if ({bus.we, bus.waddr, bus.wdata} !== {1'b1, 5'(10 + i), 32'h100 + i})
                begin n_fail++; $display("FAIL full_drain%0d: got we=%b a=%0d d=%h want a=%0d", i, bus.we, bus.waddr, bus.wdata, 10 + i); end
            n_checks++; if (bus.q_count !== 3'(3 - i) || bus.m_ready !== 1'b1)
                begin n_fail++; $display("FAIL full_cnt%0d: got cnt=%0d rdy=%b want %0d 1", i, bus.q_count, bus.m_ready, 3 - i); end
        end
        tick();
        n_checks++; if (bus.we !== 1'b0) begin n_fail++; $display("FAIL full_done: got we=%b want 0", bus.we); end
    endtask

    task automatic test_waw_kill();
        bus.m_valid = 1'b1; bus.m_addr = 5'd7; bus.m_data = 32'h11;
        tick();
        bus.m_valid = 1'b0;
        n_checks++; if (bus.pend_mask !== 32'h80) begin n_fail++; $display("FAIL waw_pend: got %h want 00000080", bus.pend_mask); end
        bus.p_valid = 1'b1; bus.p_addr = 5'd7; bus.p_data = 32'h22;
        tick();
        bus.p_valid = 1'b0;
        n_checks++; if ({bus.we, bus.waddr, bus.wdata} !== {1'b1, 5'd7, 32'h22})
            begin n_fail++; $display("FAIL waw_p: got we=%b a=%0d d=%h want 1 7 22", bus.we, bus.waddr, bus.wdata); end
        n_checks++; if (bus.pend_mask !== 32'h0 || bus.q_count !== 3'd1)
            begin n_fail++; $display("FAIL waw_killed: got pend=%h cnt=%0d want 0 1", bus.pend_mask, bus.q_count); end
        tick();
        n_checks++; if (bus.we !== 1'b0 || bus.q_count !== 3'd0)
            begin n_fail++; $display("FAIL waw_silent: got we=%b cnt=%0d want 0 0", bus.we, bus.q_count); end
    endtask

    task automatic test_waw_same_cycle();
        bus.m_valid = 1'b1; bus.m_addr = 5'd7; bus.m_data = 32'h33;
        bus.p_valid = 1'b1; bus.p_addr = 5'd7; bus.p_data = 32'h44;
        tick();
        idle_inputs();
        n_checks++; if ({bus.we, bus.waddr, bus.wdata} !== {1'b1, 5'd7, 32'h44})
            begin n_fail++; $display("FAIL same_p: got we=%b a=%0d d=%h want 1 7 44", bus.we, bus.waddr, bus.wdata); end
        n_checks++; if (bus.pend_mask !== 32'h0 || bus.q_count !== 3'd1)
            begin n_fail++; $display("FAIL same_killed: got pend=%h cnt=%0d want 0 1", bus.pend_mask, bus.q_count); end
        tick();
        n_checks++; if (bus.we !== 1'b0 || bus.q_count !== 3'd0)
            begin n_fail++; $display("FAIL same_silent: got we=%b cnt=%0d want 0 0", bus.we, bus.q_count); end
    endtask

    task automatic test_mid_reset();
        bus.p_valid = 1'b1; bus.p_addr = 5'd9; bus.p_data = 32'h9;
        for (int i = 0; i < 3; i++) begin
            bus.m_valid = 1'b1; bus.m_addr = 5'(20 + i); bus.m_data = 32'h200 + i;
            tick();
        end
        n_checks++; if (bus.q_count !== 3'd3 || bus.pend_mask !== 32'h700000)
            begin n_fail++; $display("FAIL mid_fill: got cnt=%0d pend=%h want 3 00700000", bus.q_count, bus.pend_mask); end
        idle_inputs();
        rst = 1'b1;
        #1;
        n_checks++; if (bus.m_ready !== 1'b0) begin n_fail++; $display("FAIL mid_rdy: got %b want 0", bus.m_ready); end
        tick();
        rst = 1'b0;
        n_checks++; if (bus.we !== 1'b0 || bus.q_count !== 3'd0 || bus.pend_mask !== 32'h0)
            begin n_fail++; $display("FAIL mid_reset: got we=%b cnt=%0d pend=%h want 0 0 0", bus.we, bus.q_count, bus.pend_mask); end
        for (int i = 0; i < 3; i++) begin
            tick();
            n_checks++; if (bus.we !== 1'b0) begin n_fail++; $display("FAIL mid_no_write%0d: got we=%b a=%0d want we=0", i, bus.we, bus.waddr); end
        end
    endtask

`ifdef WB_BYPASS_EN
    task automatic test_bypass();
        bus.p_valid = 1'b1; bus.p_addr = 5'd12; bus.p_data = 32'hCAFE;
        tick();
        idle_inputs();
        ra_addr = 5'd12; rb_addr = 5'd13;
        #1;
        n_checks++; if ({ra_fwd_hit, ra_fwd_data} !== {1'b1, 32'hCAFE})
            begin n_fail++; $display("FAIL byp_ra: got %b %h want 1 cafe", ra_fwd_hit, ra_fwd_data); end
        n_checks++; if ({rb_fwd_hit, rb_fwd_data} !== {1'b0, 32'h0})
            begin n_fail++; $display("FAIL byp_rb: got %b %h want 0 0", rb_fwd_hit, rb_fwd_data); end
        tick();
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        idle_inputs();
        test_reset();
        test_p_write();
        test_m_drain();
        test_full();
        test_waw_kill();
        test_waw_same_cycle();
        test_mid_reset();
`ifdef WB_BYPASS_EN
        test_bypass();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/regfile_wb_ctrl.md
Name: regfile_wb_ctrl

Overview:
Write-side controller for the CPU register file. It collects writeback results from two producers:
- the in-order pipeline writeback stage (source P);
- the multi-cycle execution unit (mul/div/load, source M).
It drives the register file's single write port (we/waddr/wdata) with a registered output. It buffers source M results in a small FIFO and publishes a pending-write scoreboard for the decode stage's stall logic.

Parameters:
DEPTH, 4, source M FIFO entries (power of two, >=2)
ADDR_W, 5, register address width
DATA_W, 32, register data width

Ports:
clk  input  1  clock, rising edge
rst  input  1  reset, synchronous, active-high
p_valid  input  1  source P write request; always accepted
p_addr  input  ADDR_W  source P destination register
p_data  input  DATA_W  source P result
m_valid  input  1  source M result valid
m_ready  output  1  source M may enqueue this cycle
m_addr  input  ADDR_W  source M destination register
m_data  input  DATA_W  source M result
we  output  1  register file write enable (registered)
waddr  output  ADDR_W  register file write address (registered)
wdata  output  DATA_W  register file write data (registered)
pend_mask  output  32  bit i set = live queued source M write to register i
q_count  output  log2(DEPTH)+1  current FIFO occupancy

Behaviour:
- Reset:
  - applied only on the clk edge with rst=1;
  - outputs: we=0, waddr=0, wdata=0, pend_mask=0, q_count=0;
  - FIFO emptied and all kill bits cleared;
  - m_ready=0 while rst=1;
  - reset mid-operation discards all queued and in-flight writes, with no write issued on the following cycle.
- Handshakes:
  - m_ready = !rst && (q_count < DEPTH), computed from registered state; no same-cycle pass-through when full.
  - An M transfer occurs when m_valid && m_ready; it always enqueues, even when the FIFO is empty (no bypass path).
- Write port arbitration, once per cycle:
  1. p_valid=1: issue P; FIFO head does not drain.
  2. p_valid=0, FIFO non-empty: dequeue head; issue it if live, otherwise dequeue silently with we=0.
  3. Otherwise: we=0.
- Latency: a request selected in cycle N appears on we/waddr/wdata after edge N+1, for exactly one cycle. we is never asserted for address 0; a zero-address request is still consumed.
- Ordering / WAW:
  - Source M results are older in program order than any concurrent or later P write.
  - When P writes address A, every live FIFO entry with addr A is marked killed.
  - An M entry enqueued in the same cycle as a P write to the same A is enqueued killed.
  - Net effect: a register's final value is always the P data.
- pend_mask:
  - bit i = OR over live FIFO entries with addr i;
  - updated on the same edge as enqueue, dequeue and kill;
  - bit 0 is always 0.
- Simultaneous enqueue and dequeue: occupancy unchanged; m_ready follows the pre-edge count.
- Pointers: read/write pointers wrap modulo DEPTH; q_count saturates by construction (enqueue is blocked at DEPTH).

Optional Feature:
WB_BYPASS_EN
- Defined: adds inputs ra_addr and rb_addr (ADDR_W) and outputs ra_fwd_hit, rb_fwd_hit (1) and ra_fwd_data, rb_fwd_data (DATA_W).
  - Combinational: hit = we && waddr==rx_addr && rx_addr!=0; data = wdata when hit, else 0.
  - The decode stage uses these to obtain a value being written in the same cycle.
- Undefined: these ports do not exist and no comparison logic is built; the core stalls instead.

Test Plan:
- Reset: hold rst=1 for 2 cycles with p_valid=1 -> we=0, m_ready=0, pend_mask=0; after release m_ready=1 and q_count=0.
- P write: p_valid=1, p_addr=3, p_data=0x1234 in cycle N -> cycle N+1: we=1, waddr=3, wdata=0x1234; cycle N+2: we=0. Repeat with p_addr=0 -> we stays 0.
- M enqueue/drain: enqueue addr 5 data 0xAA and addr 6 data 0xBB with p_valid=0 -> pend_mask bits 5 and 6 set; writes appear in order 5 then 6 on consecutive cycles; pend_mask returns to 0.
- Full FIFO: hold p_valid=1 (addr 9) while enqueuing 4 M entries -> m_ready=0 with q_count=4; a 5th m_valid is not accepted; after p_valid drops, 4 drain cycles follow and m_ready rises after the first dequeue.
- WAW kill: enqueue M addr 7 data 0x11, then P addr 7 data 0x22 -> port writes 0x22 to r7; the drain cycle for the M entry shows we=0; pend_mask[7] clears on the P cycle. Same-cycle variant gives an identical result.
- Mid-operation reset with 3 queued entries -> no writes issued after rst; q_count=0.
